// File: rtl/digi_ota_array.sv
// digi_ota_array: clocked multi-channel digital OTA output stage.
// Each channel synchronises a vip/vin comparator pair, filters the resulting
// class (UP / DN / EQ), and drives a tristate pad pair through a small FSM
// that sources, sinks or releases the pad, with dead time on reversals.
module digi_ota_array #(
    parameter int CH   = 4,  // number of independent channels
    parameter int FILT = 3,  // identical consecutive samples to accept a class (1..15)
    parameter int DEAD = 2   // oe=0 cycles inserted on SRC<->SNK reversal (0..15)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   en,
    input  logic            hold_mode,
    input  logic [CH-1:0]   vip,
    input  logic [CH-1:0]   vin,
    output logic [CH-1:0]   out,
    output logic [CH-1:0]   oe,
    output logic [2*CH-1:0] state
);

    // State codes double as the externally visible state field.
    typedef enum logic [1:0] {
        ST_HIZ  = 2'b00,
        ST_SRC  = 2'b01,
        ST_SNK  = 2'b10,
        ST_DEAD = 2'b11
    } state_e;

    // Input class of a synchronised vip/vin pair.
    typedef enum logic [1:0] {
        CL_EQ = 2'b00,
        CL_UP = 2'b01,
        CL_DN = 2'b10
    } class_e;

    localparam logic [3:0] FILT_C = 4'(FILT);
    localparam logic [3:0] DEAD_C = 4'(DEAD);

    logic [CH-1:0] r_vip_s1;
    logic [CH-1:0] r_vip_s2;
    logic [CH-1:0] r_vin_s1;
    logic [CH-1:0] r_vin_s2;

    // Two-flop synchronisers on the asynchronous inputs; they ignore en so a
    // re-enabled channel sees already settled samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vip_s1 <= '0;
            r_vip_s2 <= '0;
            r_vin_s1 <= '0;
            r_vin_s2 <= '0;
        end else begin
            // NOTE: non-blocking so the second stage captures the first stage's
            // pre-edge value, giving a true two-flop chain.
            r_vip_s1 <= vip;
            r_vip_s2 <= r_vip_s1;
            r_vin_s1 <= vin;
            r_vin_s2 <= r_vin_s1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        class_e     r_cand;   // class currently being counted
        logic [3:0] r_cnt;    // consecutive samples of r_cand, saturates at FILT
        state_e     r_st;     // channel state, outputs decode directly from it
        state_e     r_tgt;    // state to enter when dead time expires
        logic [3:0] r_dcnt;   // remaining dead-time cycles

        class_e     w_class;
        logic       w_acc_up;
        logic       w_acc_dn;
        logic       w_acc_eq;
        state_e     w_tgt;

        // Classify the synchronised pair.
        always_comb begin
            // NOTE: default assignment first so every path writes w_class and
            // no latch is inferred.
            w_class = CL_EQ;
            if (r_vip_s2[g] && !r_vin_s2[g]) begin
                w_class = CL_UP;
            end else if (!r_vip_s2[g] && r_vin_s2[g]) begin
                w_class = CL_DN;
            end
        end

        // A class is accepted on every cycle the filter holds it at FILT.
        assign w_acc_up = (r_cnt == FILT_C) && (r_cand == CL_UP);
        assign w_acc_dn = (r_cnt == FILT_C) && (r_cand == CL_DN);
        assign w_acc_eq = (r_cnt == FILT_C) && (r_cand == CL_EQ);

        // Dead-time target after any retarget by an accepted UP/DN.
        always_comb begin
            w_tgt = r_tgt;
            if (w_acc_up) begin
                w_tgt = ST_SRC;
            end else if (w_acc_dn) begin
                w_tgt = ST_SNK;
            end
        end

        // Glitch filter and channel FSM; rst beats en, en=0 parks the channel.
        always_ff @(posedge clk) begin
            if (rst || !en[g]) begin
                r_cand <= CL_EQ;
                r_cnt  <= '0;
                r_st   <= ST_HIZ;
                r_tgt  <= ST_HIZ;
                r_dcnt <= '0;
            end else begin
                if (w_class != r_cand) begin
                    r_cand <= w_class;
                    r_cnt  <= 4'd1;
                end else if (r_cnt != FILT_C) begin
                    r_cnt  <= r_cnt + 4'd1;
                end

                case (r_st)
                    ST_HIZ: begin
                        if (w_acc_up) begin
                            r_st <= ST_SRC;
                        end else if (w_acc_dn) begin
                            r_st <= ST_SNK;
                        end
                    end
                    ST_SRC: begin
                        if (w_acc_dn) begin
                            if (DEAD_C == 4'd0) begin
                                r_st <= ST_SNK;
                            end else begin
                                r_st   <= ST_DEAD;
                                r_tgt  <= ST_SNK;
                                r_dcnt <= DEAD_C;
                            end
                        end else if (w_acc_eq && !hold_mode) begin
                            r_st <= ST_HIZ;
                        end
                    end
                    ST_SNK: begin
                        if (w_acc_up) begin
                            if (DEAD_C == 4'd0) begin
                                r_st <= ST_SRC;
                            end else begin
                                r_st   <= ST_DEAD;
                                r_tgt  <= ST_SRC;
                                r_dcnt <= DEAD_C;
                            end
                        end else if (w_acc_eq && !hold_mode) begin
                            r_st <= ST_HIZ;
                        end
                    end
                    ST_DEAD: begin
                        if (w_acc_eq && !hold_mode) begin
                            r_st   <= ST_HIZ;
                            r_dcnt <= '0;
                        end else begin
                            // Retarget keeps the running dead-time count.
                            r_tgt <= w_tgt;
                            if (r_dcnt == 4'd1) begin
                                r_st   <= w_tgt;
                                r_dcnt <= '0;
                            end else begin
                                r_dcnt <= r_dcnt - 4'd1;
                            end
                        end
                    end
                    default: r_st <= ST_HIZ;
                endcase
            end
        end

        assign state[2*g +: 2] = r_st;
        assign out[g]          = (r_st == ST_SRC);
        assign oe[g]           = (r_st == ST_SRC) || (r_st == ST_SNK);
    end

endmodule

// File: tb/tb_digi_ota_array.sv
// tb_digi_ota_array: randomized and directed checks of digi_ota_array against
// a cycle-level reference model built from the channel rules. Instance u_dut
// uses the default parameters; u_ret uses a long dead time so a retarget can
// land inside it.
module tb_digi_ota_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold_mode;
    logic [3:0] en0, vip0, vin0, out0, oe0;
    logic [7:0] st0;
    logic [0:0] en1, vip1, vin1, out1, oe1;
    logic [1:0] st1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digi_ota_array #(.CH(4), .FILT(3), .DEAD(2)) u_dut (
        .clk(clk), .rst(rst), .en(en0), .hold_mode(hold_mode),
        .vip(vip0), .vin(vin0), .out(out0), .oe(oe0), .state(st0)
    );

    digi_ota_array #(.CH(1), .FILT(2), .DEAD(6)) u_ret (
        .clk(clk), .rst(rst), .en(en1), .hold_mode(hold_mode),
        .vip(vip1), .vin(vin1), .out(out1), .oe(oe1), .state(st1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Classes: 0=EQ 1=UP 2=DN. States: 0=HIZ 1=SRC 2=SNK 3=DEAD.
    localparam int NI = 2;
    bit     m_s1v [NI][4];
    bit     m_s1n [NI][4];
    bit     m_s2v [NI][4];
    bit     m_s2n [NI][4];
    int     m_hist[NI][4][16];  // filter-input classes since last clear
    int     m_hlen[NI][4];
    int     m_st  [NI][4];
    int     m_tgt [NI][4];
    longint m_dend[NI][4];      // edge number at which dead time ends
    longint m_edge = 0;
    bit     m_valid = 1'b0;

    task automatic model_step();
        m_edge++;
        if (rst) m_valid = 1'b1;
        for (int i = 0; i < NI; i++) begin
            int nch;
            int f;
            int d;
            nch = (i == 0) ? 4 : 1;
            f   = (i == 0) ? 3 : 2;
            d   = (i == 0) ? 2 : 6;
            for (int c = 0; c < nch; c++) begin
                bit iv;
                bit in_;
                bit ie;
                int acc;
                int cls;
                bit same;
                iv  = (i == 0) ? vip0[c] : vip1[0];
                in_ = (i == 0) ? vin0[c] : vin1[0];
                ie  = (i == 0) ? en0[c]  : en1[0];
                if (rst) begin
                    m_s1v[i][c] = 0; m_s1n[i][c] = 0;
                    m_s2v[i][c] = 0; m_s2n[i][c] = 0;
                    m_hlen[i][c] = 0; m_st[i][c] = 0;
                    m_tgt[i][c] = 0;  m_dend[i][c] = 0;
                    continue;
                end
                // Accepted class: the last f filter samples are all identical.
                acc = -1;
                if (m_hlen[i][c] >= f) begin
                    same = 1'b1;
                    for (int j = 1; j <= f; j++)
                        if (m_hist[i][c][m_hlen[i][c]-j] != m_hist[i][c][m_hlen[i][c]-1]) same = 1'b0;
                    if (same) acc = m_hist[i][c][m_hlen[i][c]-1];
                end
                cls = (m_s2v[i][c] && !m_s2n[i][c]) ? 1 : (!m_s2v[i][c] && m_s2n[i][c]) ? 2 : 0;
                if (!ie) begin
                    m_st[i][c] = 0;
                    m_hlen[i][c] = 0;
                end else begin
                    if (m_hlen[i][c] == 16) begin
                        for (int j = 0; j < 15; j++) m_hist[i][c][j] = m_hist[i][c][j+1];
                        m_hist[i][c][15] = cls;
                    end else begin
                        m_hist[i][c][m_hlen[i][c]] = cls;
                        m_hlen[i][c]++;
                    end
                    case (m_st[i][c])
                        0: if (acc == 1) m_st[i][c] = 1; else if (acc == 2) m_st[i][c] = 2;
                        1, 2: begin
                            if (acc == 3 - m_st[i][c]) begin
                                if (d == 0) m_st[i][c] = acc;
                                else begin
                                    m_tgt[i][c] = acc;
                                    m_st[i][c] = 3;
                                    m_dend[i][c] = m_edge + d;
                                end
                            end else if (acc == 0 && !hold_mode) m_st[i][c] = 0;
                        end
                        default: begin
                            if (acc == 0 && !hold_mode) m_st[i][c] = 0;
                            else begin
                                if (acc == 1 || acc == 2) m_tgt[i][c] = acc;
                                if (m_edge == m_dend[i][c]) m_st[i][c] = m_tgt[i][c];
                            end
                        end
                    endcase
                end
                m_s2v[i][c] = m_s1v[i][c]; m_s2n[i][c] = m_s1n[i][c];
                m_s1v[i][c] = iv;          m_s1n[i][c] = in_;
            end
        end
    endtask

    // Expected {state, oe, out} of instance i, packed like the DUT ports.
    function automatic logic [31:0] exp_pack(input int i);
        int nch;
        logic [31:0] s;
        logic [31:0] o;
        logic [31:0] u;
        nch = (i == 0) ? 4 : 1;
        s = '0; o = '0; u = '0;
        for (int c = 0; c < nch; c++) begin
            s = s | (32'(m_st[i][c]) << (2 * c));
            if (m_st[i][c] == 1 || m_st[i][c] == 2) o[c] = 1'b1;
            if (m_st[i][c] == 1) u[c] = 1'b1;
        end
        return (s << (2 * nch)) | (o << nch) | u;
    endfunction

    // Advance the model on each edge and compare just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check("cycle.inst0", {st0, oe0, out0}, exp_pack(0));
            check("cycle.inst1", {st1, oe1, out1}, exp_pack(1));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        rst = 1'b1; hold_mode = 1'b0;
        en0 = 4'hF; vip0 = 4'hF; vin0 = 4'h0;
        en1 = 1'b1; vip1 = 1'b1; vin1 = 1'b0;

        // Reset held two cycles with UP applied.
        @(negedge clk);
        check("rst1.state", st0, 8'h00); check("rst1.oe", oe0, 4'h0); check("rst1.out", out0, 4'h0);
        @(negedge clk);
        check("rst2.state", st0, 8'h00); check("rst2.oe", oe0, 4'h0);
        rst = 1'b0;
        wait_neg(5);
        check("rel5.oe", oe0, 4'h0);
        wait_neg(1);
        check("rel6.state", st0, 8'h55); check("rel6.oe", oe0, 4'hF); check("rel6.out", out0, 4'hF);

        // Release everything, then glitch ch0.
        vip0 = 4'h0;
        wait_neg(10);
        check("eq.state", st0, 8'h00);
        vip0[0] = 1'b1; wait_neg(2); vip0[0] = 1'b0;
        wait_neg(10);
        check("glitch2.state", st0[1:0], 2'b00);
        vip0[0] = 1'b1; wait_neg(3); vip0[0] = 1'b0;
        wait_neg(3);
        check("pulse3.n6", st0[1:0], 2'b01);
        wait_neg(2);
        check("pulse3.n8", st0[1:0], 2'b01);
        wait_neg(1);
        check("pulse3.n9", st0[1:0], 2'b00);

        // Dead time on ch1 reversal SRC -> SNK.
        vip0[1] = 1'b1;
        wait_neg(10);
        check("dead.src", st0[3:2], 2'b01);
        vip0[1] = 1'b0; vin0[1] = 1'b1;
        wait_neg(5); check("dead.n5", {st0[3:2], oe0[1], out0[1]}, 4'b0111);
        wait_neg(1); check("dead.n6", {st0[3:2], oe0[1], out0[1]}, 4'b1100);
        wait_neg(1); check("dead.n7", {st0[3:2], oe0[1], out0[1]}, 4'b1100);
        wait_neg(1); check("dead.n8", {st0[3:2], oe0[1], out0[1]}, 4'b1010);

        // Hold mode on ch2.
        vin0[2] = 1'b1;
        wait_neg(10);
        check("hold.snk", st0[5:4], 2'b10);
        hold_mode = 1'b1; vin0[2] = 1'b0;
        wait_neg(10);
        check("hold.keep", {st0[5:4], oe0[2], out0[2]}, 4'b1010);
        vin0[2] = 1'b1;
        wait_neg(10);
        hold_mode = 1'b0;
        wait_neg(2);
        vin0[2] = 1'b0;
        wait_neg(5); check("hold.n5", st0[5:4], 2'b10);
        wait_neg(1); check("hold.n6", st0[5:4], 2'b00);

        // Enable and channel independence on ch3.
        vip0[3] = 1'b1;
        wait_neg(10);
        check("en.before", st0, 8'h48);
        en0[3] = 1'b0;
        wait_neg(1);
        check("en.off.state", st0, 8'h08); check("en.off.oe", oe0, 4'b0010);
        wait_neg(3);
        en0[3] = 1'b1;
        wait_neg(3); check("en.on.n3", st0[7:6], 2'b00);
        wait_neg(1); check("en.on.n4", st0, 8'h48);

        // Retarget inside a long dead time on u_ret (FILT=2, DEAD=6).
        check("ret.src", st1, 2'b01);
        vip1 = 1'b0; vin1 = 1'b1;
        wait_neg(4); check("ret.n4", st1, 2'b01);
        wait_neg(1); check("ret.n5", st1, 2'b11);
        vip1 = 1'b1; vin1 = 1'b0;
        wait_neg(5); check("ret.n10", {st1, oe1}, 3'b110);
        wait_neg(1); check("ret.n11", {st1, oe1, out1}, 4'b0111);

        // Randomized traffic, one segment per hold_mode value. hold_mode only
        // changes while every channel has UP accepted.
        for (int seg = 0; seg < 2; seg++) begin
            rst = 1'b0; en0 = 4'hF; en1 = 1'b1;
            vip0 = 4'hF; vin0 = 4'h0; vip1 = 1'b1; vin1 = 1'b0;
            wait_neg(10);
            hold_mode = (seg == 1);
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 399) == 0);
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        vip0[c] = 1'($urandom_range(0, 1));
                        vin0[c] = 1'($urandom_range(0, 1));
                    end
                end
                if ($urandom_range(0, 5) == 0) begin
                    vip1[0] = 1'($urandom_range(0, 1));
                    vin1[0] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 59) == 0) begin
                    idx = int'($urandom_range(0, 3));
                    en0[idx] = ~en0[idx];
                end
                if ($urandom_range(0, 89) == 0) en1[0] = ~en1[0];
            end
        end

        wait_neg(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
